// File: rtl/fract_load_scheduler_if.sv
// rtl/fract_load_scheduler_if.sv - pixel dispatch and result write-back bus of the frame scheduler
`timescale 1ns/1ps
interface fract_load_scheduler_if #(
  parameter int NUM_PROC = 4
);
  logic                     iStart;
  logic [35:0]              iOriginX;
  logic [35:0]              iOriginY;
  logic [35:0]              iStep;
  logic                     oBusy;
  logic                     oFrameDone;
  logic [NUM_PROC-1:0]      iProcReady;
  logic [NUM_PROC-1:0]      oDataVal;
  logic [35:0]              oCoordX;
  logic [35:0]              oCoordY;
  logic [9:0]               oVGAX;
  logic [8:0]               oVGAY;
  logic [NUM_PROC-1:0]      iVGAVal;
  logic [3*NUM_PROC-1:0]    iColor;
  logic [19*NUM_PROC-1:0]   iVGACoord;
  logic [NUM_PROC-1:0]      oValueStored;
  logic                     iBufReady;
  logic                     oWrEn;
  logic [18:0]              oWrAddr;
  logic [2:0]               oWrData;

  modport master (
    input  iStart, iOriginX, iOriginY, iStep, iProcReady, iVGAVal, iColor, iVGACoord, iBufReady,
    output oBusy, oFrameDone, oDataVal, oCoordX, oCoordY, oVGAX, oVGAY, oValueStored,
           oWrEn, oWrAddr, oWrData
  );

  modport slave (
    output iStart, iOriginX, iOriginY, iStep, iProcReady, iVGAVal, iColor, iVGACoord, iBufReady,
    input  oBusy, oFrameDone, oDataVal, oCoordX, oCoordY, oVGAX, oVGAY, oValueStored,
           oWrEn, oWrAddr, oWrData
  );
endinterface

// File: rtl/fract_load_scheduler.sv
// rtl/fract_load_scheduler.sv - raster scan, round-robin pixel dispatch and result write-back arbiter
`timescale 1ns/1ps
module fract_load_scheduler #(
  parameter int NUM_PROC = 4,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480
) (
  input  logic                    clk,
  input  logic                    reset,
  fract_load_scheduler_if.master  bus
);

  localparam int PW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Returns {found, index} of the first set request at or after ptr.
  function automatic logic [PW:0] rr_pick(input logic [NUM_PROC-1:0] req, input logic [PW-1:0] ptr);
    logic [PW:0] res;
    logic [PW:0] idx;
    res = '0;
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_PROC)) idx = idx - (PW+1)'(NUM_PROC);
      if (req[idx[PW-1:0]]) res = {1'b1, idx[PW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(NUM_PROC - 1)) ? '0 : p + 1'b1;
  endfunction

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_PROC-1:0]   data_val_q, data_val_d;
  logic [NUM_PROC-1:0]   value_stored_q, value_stored_d;
  logic [NUM_PROC-1:0]   claimed_q, claimed_d;
  logic [NUM_PROC-1:0]   acked_q, acked_d;
  logic [35:0]           coord_x_q, coord_x_d;
  logic [35:0]           coord_y_q, coord_y_d;
  logic [35:0]           cx_q, cx_d;
  logic [35:0]           cy_q, cy_d;
  logic [35:0]           origin_x_q, origin_x_d;
  logic [35:0]           step_q, step_d;
  logic [9:0]            vga_x_q, vga_x_d;
  logic [8:0]            vga_y_q, vga_y_d;
  logic [9:0]            x_q, x_d;
  logic [8:0]            y_q, y_d;
  logic                  wr_en_q, wr_en_d;
  logic [18:0]           wr_addr_q, wr_addr_d;
  logic [2:0]            wr_data_q, wr_data_d;
  logic [18:0]           outstanding_q, outstanding_d;
  logic [PW-1:0]         disp_ptr_q, disp_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;

  logic [PW:0]           disp_pick, wr_pick;
  logic [NUM_PROC-1:0]   disp_oh, wr_oh;
  logic                  dispatch, grant, last_pixel;

  always_comb begin
    state_d        = state_q;
    busy_d         = busy_q;
    frame_done_d   = 1'b0;
    data_val_d     = '0;
    value_stored_d = '0;
    wr_en_d        = 1'b0;
    coord_x_d      = coord_x_q;
    coord_y_d      = coord_y_q;
    vga_x_d        = vga_x_q;
    vga_y_d        = vga_y_q;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    cx_d           = cx_q;
    cy_d           = cy_q;
    origin_x_d     = origin_x_q;
    step_d         = step_q;
    x_d            = x_q;
    y_d            = y_q;
    outstanding_d  = outstanding_q;
    disp_ptr_d     = disp_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    // A processor's ready drop releases its claim; a valid drop releases its ack.
    claimed_d      = claimed_q & bus.iProcReady;
    acked_d        = acked_q & bus.iVGAVal;

    disp_pick  = rr_pick(bus.iProcReady & ~claimed_q, disp_ptr_q);
    wr_pick    = rr_pick(bus.iVGAVal & ~acked_q, wr_ptr_q);
    disp_oh    = NUM_PROC'(1) << disp_pick[PW-1:0];
    wr_oh      = NUM_PROC'(1) << wr_pick[PW-1:0];
    dispatch   = (state_q == S_RUN) && disp_pick[PW];
    grant      = ((state_q == S_RUN) || (state_q == S_DRAIN)) && bus.iBufReady && wr_pick[PW];
    last_pixel = (x_q == 10'(H_RES - 1)) && (y_q == 9'(V_RES - 1));

    case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          state_d       = S_RUN;
          busy_d        = 1'b1;
          origin_x_d    = bus.iOriginX;
          step_d        = bus.iStep;
          cx_d          = bus.iOriginX;
          cy_d          = bus.iOriginY;
          x_d           = '0;
          y_d           = '0;
          outstanding_d = '0;
          claimed_d     = '0;
          acked_d       = '0;
        end
      end
      S_RUN: begin
        if (dispatch && last_pixel) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (outstanding_q == '0 && !wr_en_q && !grant) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (dispatch) begin
      data_val_d = disp_oh;
      coord_x_d  = cx_q;
      coord_y_d  = cy_q;
      vga_x_d    = x_q;
      vga_y_d    = y_q;
      claimed_d  = claimed_d | disp_oh;
      disp_ptr_d = inc_ptr(disp_pick[PW-1:0]);
      // Coordinates advance incrementally; a line wrap reloads X and steps Y down.
      if (x_q == 10'(H_RES - 1)) begin
        x_d  = '0;
        y_d  = y_q + 9'd1;
        cx_d = origin_x_q;
        cy_d = cy_q - step_q;
      end else begin
        x_d  = x_q + 10'd1;
        cx_d = cx_q + step_q;
      end
    end

    if (grant) begin
      wr_en_d        = 1'b1;
      wr_addr_d      = bus.iVGACoord[19*int'(wr_pick[PW-1:0]) +: 19];
      wr_data_d      = bus.iColor[3*int'(wr_pick[PW-1:0]) +: 3];
      value_stored_d = wr_oh;
      acked_d        = acked_d | wr_oh;
      wr_ptr_d       = inc_ptr(wr_pick[PW-1:0]);
    end

    if (dispatch && !grant)      outstanding_d = outstanding_q + 19'd1;
    else if (!dispatch && grant) outstanding_d = outstanding_q - 19'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      data_val_q     <= '0;
      value_stored_q <= '0;
      claimed_q      <= '0;
      acked_q        <= '0;
      coord_x_q      <= '0;
      coord_y_q      <= '0;
      cx_q           <= '0;
      cy_q           <= '0;
      origin_x_q     <= '0;
      step_q         <= '0;
      vga_x_q        <= '0;
      vga_y_q        <= '0;
      x_q            <= '0;
      y_q            <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      outstanding_q  <= '0;
      disp_ptr_q     <= '0;
      wr_ptr_q       <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      data_val_q     <= data_val_d;
      value_stored_q <= value_stored_d;
      claimed_q      <= claimed_d;
      acked_q        <= acked_d;
      coord_x_q      <= coord_x_d;
      coord_y_q      <= coord_y_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      origin_x_q     <= origin_x_d;
      step_q         <= step_d;
      vga_x_q        <= vga_x_d;
      vga_y_q        <= vga_y_d;
      x_q            <= x_d;
      y_q            <= y_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      outstanding_q  <= outstanding_d;
      disp_ptr_q     <= disp_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
    end
  end

  assign bus.oBusy        = busy_q;
  assign bus.oFrameDone   = frame_done_q;
  assign bus.oDataVal     = data_val_q;
  assign bus.oCoordX      = coord_x_q;
  assign bus.oCoordY      = coord_y_q;
  assign bus.oVGAX        = vga_x_q;
  assign bus.oVGAY        = vga_y_q;
  assign bus.oValueStored = value_stored_q;
  assign bus.oWrEn        = wr_en_q;
  assign bus.oWrAddr      = wr_addr_q;
  assign bus.oWrData      = wr_data_q;

endmodule
